// File: rtl/sr_input_scanner_pkg.sv
// Shared constants for the 74HC165 input scanner: clock default, FSM encodings
// and a constant-width helper.
package sr_input_scanner_pkg;

  localparam int DEFAULT_CLOCK = 12_000_000;
  localparam int SYNC_STAGES   = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_SHIFT_HI = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Smallest width able to index `value` distinct codes (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sr_input_scanner_tick_div.sv
// Half-period divider for the serial clock: tick marks the last cycle of every
// HALF-cycle window, and restart realigns the window to a new FSM state.
module sr_tick_div
  import sr_input_scanner_pkg::*;
#(
  parameter int HALF = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (HALF > 1) ? clog2(HALF) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == CW'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (restart || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sr_input_scanner.sv
// Periodically reads a 74HC165 chain over SCK/PL_n/SER and presents a word that
// has been seen identically on STABLE_SCANS consecutive scans.
module sr_input_scanner
  import sr_input_scanner_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int CLOCK        = DEFAULT_CLOCK,
  parameter int SCK_HZ       = 1_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int STABLE_SCANS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sr_ser,
  output logic            sr_sck,
  output logic            sr_pl_n,
  output logic [BITS-1:0] data,
  output logic            valid,
  output logic            changed
);

  localparam int HALF   = CLOCK / (2 * SCK_HZ);
  localparam int PERIOD = CLOCK / SCAN_HZ;
  localparam int TW     = clog2(PERIOD);
  localparam int BCW    = clog2(BITS);
  localparam int SCW    = clog2(STABLE_SCANS + 1);

  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic [TW-1:0]          timer_reg;
  logic                   pending_reg;
  logic                   load_phase_reg;
  logic [BCW-1:0]         bit_cnt_reg;
  logic [BITS-1:0]        raw_reg;
  logic [BITS-1:0]        prev_raw_reg;
  logic [BITS-1:0]        data_reg;
  logic [SCW-1:0]         stable_reg;
  logic [SCW-1:0]         stable_next;
  logic [SYNC_STAGES-1:0] ser_sync_reg;
  logic                   sck_reg;
  logic                   pl_n_reg;

  logic expire;
  logic scan_due;
  logic restart;
  logic tick;
  logic entering_load;
  logic last_bit;
  logic accept;
  logic ser_synced;

  assign expire        = (timer_reg == TW'(PERIOD - 1));
  assign scan_due      = pending_reg || expire;
  assign restart       = (state_next != state_reg);
  assign entering_load = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
  assign last_bit      = (bit_cnt_reg == BCW'(BITS - 1));
  assign ser_synced    = ser_sync_reg[SYNC_STAGES-1];

  sr_tick_div #(
    .HALF(HALF)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (scan_due) state_next = ST_LOAD;
      ST_LOAD:     if (tick && load_phase_reg) state_next = ST_SETTLE;
      ST_SETTLE:   if (tick) state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick) state_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_next = last_bit ? ST_DONE : ST_SHIFT_LO;
      // A timer expiry seen during the scan starts the next one straight away.
      ST_DONE:     state_next = scan_due ? ST_LOAD : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Length of the current run of identical raw scans, saturating at STABLE_SCANS.
  always_comb begin
    stable_next = stable_reg;
    if (raw_reg != prev_raw_reg) begin
      stable_next = SCW'(1);
    end else if (stable_reg != SCW'(STABLE_SCANS)) begin
      stable_next = stable_reg + 1'b1;
    end
  end

  assign accept = (stable_next == SCW'(STABLE_SCANS)) && (raw_reg != data_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      pending_reg    <= 1'b0;
      load_phase_reg <= 1'b0;
      bit_cnt_reg    <= '0;
      raw_reg        <= '0;
      prev_raw_reg   <= '0;
      data_reg       <= '0;
      stable_reg     <= '0;
      ser_sync_reg   <= '0;
      sck_reg        <= 1'b0;
      pl_n_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= expire ? '0 : timer_reg + 1'b1;
      ser_sync_reg <= {ser_sync_reg[SYNC_STAGES-2:0], sr_ser};
      // Pins are registered from the next state so they switch glitch-free with it.
      sck_reg      <= (state_next == ST_SHIFT_HI);
      pl_n_reg     <= (state_next != ST_LOAD);

      if (entering_load) begin
        pending_reg <= 1'b0;
      end else if (expire) begin
        pending_reg <= 1'b1;
      end

      if (restart) begin
        load_phase_reg <= 1'b0;
      end else if (state_reg == ST_LOAD && tick) begin
        load_phase_reg <= 1'b1;
      end

      if (entering_load) begin
        bit_cnt_reg <= '0;
      end else if (state_reg == ST_SHIFT_HI && tick) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end

      if (state_reg == ST_SHIFT_LO && tick) begin
        raw_reg <= {raw_reg[BITS-2:0], ser_synced};
      end

      if (state_reg == ST_DONE) begin
        prev_raw_reg <= raw_reg;
        stable_reg   <= stable_next;
        if (accept) data_reg <= raw_reg;
      end
    end
  end

  assign sr_sck  = sck_reg;
  assign sr_pl_n = pl_n_reg;
  assign data    = data_reg;
  assign valid   = (state_reg == ST_DONE);
  assign changed = (state_reg == ST_DONE) && accept;

endmodule

// File: tb/tb_sr_input_scanner.sv
// Bench for sr_input_scanner: models 74HC165 chains and checks scan timing and
// whole-word debouncing against a scan-history reference model.
`timescale 1ns/1ps
module tb_sr_input_scanner;

  localparam int PERIOD  = 300;   // 12 MHz / 40 kHz scan rate
  localparam int S       = 3;
  localparam int SCK_PER = 12;
  localparam int LEN16   = 211;
  localparam int LEN8    = 58;
  localparam int LIMIT   = PERIOD + 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sr_ser, sr_sck, sr_pl_n, valid, changed;
  logic [15:0] data;
  logic        sr_ser8, sr_sck8, sr_pl_n8, valid8, changed8;
  logic [7:0]  data8;

  logic [15:0] sw = '0;
  logic [15:0] chain = '0;
  logic [7:0]  sw8 = '0;
  logic [7:0]  chain8 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  sr_input_scanner #(
    .BITS(16), .CLOCK(12_000_000), .SCK_HZ(1_000_000), .SCAN_HZ(40_000), .STABLE_SCANS(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sr_ser(sr_ser), .sr_sck(sr_sck), .sr_pl_n(sr_pl_n),
    .data(data), .valid(valid), .changed(changed)
  );

  sr_input_scanner #(
    .BITS(8), .CLOCK(12_000_000), .SCK_HZ(2_000_000), .SCAN_HZ(40_000), .STABLE_SCANS(1)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sr_ser(sr_ser8), .sr_sck(sr_sck8), .sr_pl_n(sr_pl_n8),
    .data(data8), .valid(valid8), .changed(changed8)
  );

  // 74HC165 chains: parallel load while PL_n low, shift on SCK rise, QH combinational.
  always @(negedge sr_pl_n or posedge sr_sck) begin
    if (!sr_pl_n) chain <= sw;
    else          chain <= {chain[14:0], 1'b0};
  end
  assign sr_ser = chain[15];

  always @(negedge sr_pl_n8 or posedge sr_sck8) begin
    if (!sr_pl_n8) chain8 <= sw8;
    else           chain8 <= {chain8[6:0], 1'b0};
  end
  assign sr_ser8 = chain8[7];

  // Reference: a word is presented once the last S scans since reset all read it.
  logic [15:0] hist[$];
  logic [15:0] model_data;

  task automatic model_reset();
    hist.delete();
    model_data = '0;
  endtask

  task automatic model_scan(input logic [15:0] raw, output logic [15:0] exp_d, output logic exp_ch);
    bit same;
    exp_ch = 1'b0;
    hist.push_back(raw);
    if (hist.size() >= S) begin
      same = 1'b1;
      for (int i = hist.size() - S; i < hist.size(); i++) if (hist[i] != raw) same = 1'b0;
      if (same && raw != model_data) begin
        model_data = raw;
        exp_ch = 1'b1;
      end
    end
    exp_d = model_data;
  endtask

  // Runs one scan of the 16-bit DUT with the switches at sw_val and reports what was seen.
  task automatic run_scan(input logic [15:0] sw_val, output logic ok, output logic [15:0] d_after,
                          output logic ch, output logic stray, output int first_low, output int len,
                          output int pl_low, output int rises, output logic sck_bad,
                          output logic pl_bad, output int vcyc, output logic v_after);
    int last_rise;
    logic prev_sck, prev_pl;
    sw = sw_val;
    ok = 1'b0; ch = 1'b0; stray = 1'b0; first_low = -1; len = 0; pl_low = 0; rises = 0;
    sck_bad = 1'b0; pl_bad = 1'b0; vcyc = 0; v_after = 1'b0; d_after = '0; last_rise = -1;
    prev_sck = sr_sck;
    prev_pl = sr_pl_n;
    for (int n = 1; n <= LIMIT && !ok; n++) begin
      @(negedge clk);
      if (!sr_pl_n) begin
        pl_low++;
        if (first_low < 0) first_low = n;
      end
      if (sr_sck && !prev_sck) begin
        if (last_rise >= 0 && (n - last_rise) != SCK_PER) sck_bad = 1'b1;
        last_rise = n;
        rises++;
      end
      if (sr_pl_n != prev_pl && (sr_sck || prev_sck)) pl_bad = 1'b1;
      if (changed && !valid) stray = 1'b1;
      if (valid) begin
        ok = 1'b1;
        ch = changed;
        len = n - first_low + 1;
        vcyc = cyc;
      end
      prev_sck = sr_sck;
      prev_pl = sr_pl_n;
    end
    if (ok) begin
      @(negedge clk);
      d_after = data;
      v_after = valid;
    end
  endtask

  task automatic test_reset();
    logic early;
    rst_n = 1'b0;
    sw = '0;
    sw8 = '0;
    repeat (5) @(negedge clk);
    checks++; if (sr_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b want=0", sr_sck); end
    checks++; if (sr_pl_n !== 1'b1) begin errors++; $display("FAIL reset_pl_n got=%b want=1", sr_pl_n); end
    checks++; if (data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h want=0000", data); end
    checks++; if (valid !== 1'b0 || changed !== 1'b0) begin
      errors++; $display("FAIL reset_pulses valid=%b changed=%b want=0,0", valid, changed);
    end
    model_reset();
    rst_n = 1'b1;
    early = 1'b0;
    for (int n = 1; n < PERIOD; n++) begin
      @(negedge clk);
      if (!sr_pl_n) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL reset_early_load got=%b want=0", early); end
  endtask

  task automatic test_pattern();
    logic ok, ch, stray, sck_bad, pl_bad, v_after, ech;
    logic [15:0] d, ed;
    int first_low, len, pl_low, rises, vcyc, prev_vcyc;
    prev_vcyc = 0;
    for (int s = 0; s < 3; s++) begin
      run_scan(16'hA5C3, ok, d, ch, stray, first_low, len, pl_low, rises, sck_bad, pl_bad, vcyc, v_after);
      model_scan(16'hA5C3, ed, ech);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pattern_valid scan=%0d got=timeout want=valid", s); end
      checks++; if (d !== ed) begin errors++; $display("FAIL pattern_data scan=%0d got=%h want=%h", s, d, ed); end
      checks++; if (ch !== ech || stray !== 1'b0) begin
        errors++; $display("FAIL pattern_changed scan=%0d got=%b stray=%b want=%b", s, ch, stray, ech);
      end
      checks++; if (len != LEN16) begin errors++; $display("FAIL pattern_len scan=%0d got=%0d want=%0d", s, len, LEN16); end
      checks++; if (pl_low != 2 * (SCK_PER / 2) * 1) begin
        errors++; $display("FAIL pattern_pl_low scan=%0d got=%0d want=%0d", s, pl_low, SCK_PER);
      end
      checks++; if (rises != 16 || sck_bad !== 1'b0) begin
        errors++; $display("FAIL pattern_sck scan=%0d rises=%0d bad=%b want=16,0", s, rises, sck_bad);
      end
      checks++; if (pl_bad !== 1'b0 || v_after !== 1'b0) begin
        errors++; $display("FAIL pattern_pins scan=%0d pl_bad=%b valid_after=%b want=0,0", s, pl_bad, v_after);
      end
      if (s == 0) begin
        checks++; if (first_low != 1) begin
          errors++; $display("FAIL pattern_first_load got=%0d want=%0d", PERIOD - 1 + first_low, PERIOD);
        end
      end else begin
        checks++; if (vcyc - prev_vcyc != PERIOD) begin
          errors++; $display("FAIL pattern_spacing scan=%0d got=%0d want=%0d", s, vcyc - prev_vcyc, PERIOD);
        end
      end
      prev_vcyc = vcyc;
    end
  endtask

  task automatic test_bounce();
    logic ok, ch, stray, sck_bad, pl_bad, v_after, ech;
    logic [15:0] d, ed;
    logic [15:0] seq [3];
    int first_low, len, pl_low, rises, vcyc;
    seq = '{16'h0000, 16'hA5C3, 16'hA5C3};
    for (int s = 0; s < 3; s++) begin
      run_scan(seq[s], ok, d, ch, stray, first_low, len, pl_low, rises, sck_bad, pl_bad, vcyc, v_after);
      model_scan(seq[s], ed, ech);
      checks++; if (ok !== 1'b1 || d !== ed) begin
        errors++; $display("FAIL bounce_data scan=%0d ok=%b got=%h want=%h", s, ok, d, ed);
      end
      checks++; if (ch !== ech || stray !== 1'b0) begin
        errors++; $display("FAIL bounce_changed scan=%0d got=%b stray=%b want=%b", s, ch, stray, ech);
      end
    end
  endtask

  task automatic test_change();
    logic ok, ch, stray, sck_bad, pl_bad, v_after, ech;
    logic [15:0] d, ed;
    int first_low, len, pl_low, rises, vcyc;
    for (int s = 0; s < 4; s++) begin
      run_scan(16'h1234, ok, d, ch, stray, first_low, len, pl_low, rises, sck_bad, pl_bad, vcyc, v_after);
      model_scan(16'h1234, ed, ech);
      checks++; if (ok !== 1'b1 || d !== ed) begin
        errors++; $display("FAIL change_data scan=%0d ok=%b got=%h want=%h", s, ok, d, ed);
      end
      checks++; if (ch !== ech || stray !== 1'b0) begin
        errors++; $display("FAIL change_changed scan=%0d got=%b stray=%b want=%b", s, ch, stray, ech);
      end
    end
  endtask

  task automatic test_reset_midscan();
    logic hit, prev_sck, ok, ch, stray, sck_bad, pl_bad, v_after, ech;
    logic [15:0] d, ed;
    int nrise, first_low, len, pl_low, rises, vcyc;
    hit = 1'b0;
    nrise = 0;
    prev_sck = sr_sck;
    for (int n = 0; n < LIMIT && !hit; n++) begin
      @(negedge clk);
      if (sr_sck && !prev_sck) nrise++;
      prev_sck = sr_sck;
      if (nrise == 8 && sr_sck) begin
        hit = 1'b1;
        rst_n = 1'b0;
      end
    end
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midscan_reach got=timeout want=bit7_high"); end
    checks++; if (sr_sck !== 1'b0 || sr_pl_n !== 1'b1) begin
      errors++; $display("FAIL midscan_pins sck=%b pl_n=%b want=0,1", sr_sck, sr_pl_n);
    end
    checks++; if (data !== 16'h0 || valid !== 1'b0 || changed !== 1'b0) begin
      errors++; $display("FAIL midscan_outputs data=%h valid=%b changed=%b want=0000,0,0", data, valid, changed);
    end
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      run_scan(16'h1234, ok, d, ch, stray, first_low, len, pl_low, rises, sck_bad, pl_bad, vcyc, v_after);
      model_scan(16'h1234, ed, ech);
      if (s == 0) begin
        checks++; if (first_low != PERIOD) begin
          errors++; $display("FAIL midscan_first_load got=%0d want=%0d", first_low, PERIOD);
        end
      end
      checks++; if (ok !== 1'b1 || d !== ed) begin
        errors++; $display("FAIL midscan_data scan=%0d ok=%b got=%h want=%h", s, ok, d, ed);
      end
      checks++; if (ch !== ech || stray !== 1'b0) begin
        errors++; $display("FAIL midscan_changed scan=%0d got=%b stray=%b want=%b", s, ch, stray, ech);
      end
    end
  endtask

  task automatic test_random();
    logic ok, ch, stray, sck_bad, pl_bad, v_after, ech;
    logic [15:0] d, ed, word;
    int first_low, len, pl_low, rises, vcyc, hold;
    for (int w = 0; w < 6; w++) begin
      word = 16'($urandom);
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        run_scan(word, ok, d, ch, stray, first_low, len, pl_low, rises, sck_bad, pl_bad, vcyc, v_after);
        model_scan(word, ed, ech);
        checks++; if (ok !== 1'b1 || d !== ed) begin
          errors++; $display("FAIL random_data word=%h hold=%0d/%0d ok=%b got=%h want=%h", word, h, hold, ok, d, ed);
        end
        checks++; if (ch !== ech || stray !== 1'b0) begin
          errors++; $display("FAIL random_changed word=%h got=%b stray=%b want=%b", word, ch, stray, ech);
        end
      end
    end
  endtask

  task automatic test_params8();
    logic [7:0] words [3];
    logic [7:0] prev, d;
    logic ok, ch;
    int first_low, len;
    words = '{8'h81, 8'h3C, 8'h3C};
    prev = 8'h00;
    rst_n = 1'b0;
    sw8 = words[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sw8 = words[s];
      ok = 1'b0; ch = 1'b0; first_low = -1; len = 0; d = '0;
      for (int n = 1; n <= LIMIT && !ok; n++) begin
        @(negedge clk);
        if (!sr_pl_n8 && first_low < 0) first_low = n;
        if (valid8) begin
          ok = 1'b1;
          ch = changed8;
          len = n - first_low + 1;
        end
      end
      @(negedge clk);
      d = data8;
      checks++; if (ok !== 1'b1 || d !== words[s]) begin
        errors++; $display("FAIL p8_data scan=%0d ok=%b got=%h want=%h", s, ok, d, words[s]);
      end
      checks++; if (ch !== (words[s] != prev)) begin
        errors++; $display("FAIL p8_changed scan=%0d got=%b want=%b", s, ch, words[s] != prev);
      end
      checks++; if (len != LEN8) begin errors++; $display("FAIL p8_len scan=%0d got=%0d want=%0d", s, len, LEN8); end
      if (s == 0) begin
        checks++; if (first_low != PERIOD) begin
          errors++; $display("FAIL p8_first_load got=%0d want=%0d", first_low, PERIOD);
        end
      end
      prev = words[s];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pattern();
    test_bounce();
    test_change();
    test_reset_midscan();
    test_random();
    test_params8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
